// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data memory between the pipeline MEM stage (CPU)
//   and an external loader/debug port (EXT). Each access holds the memory
//   bus stable for MEM_LAT cycles, then spends one response cycle in which
//   the owner is released (CPU: stall drops, EXT: ack pulses). At least one
//   idle cycle separates consecutive accesses.
//   The CPU wins simultaneous requests unless EXT has already lost
//   STARVE_MAX arbitrations in a row, in which case EXT is forced through.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata       MEM stage request, held until cpu_stall drops
//   cpu_rdata, cpu_stall        registered load data, combinational stall
//   ext_req/we/addr/wdata       external request, held until ext_ack
//   ext_rdata, ext_ack          registered read data, one-cycle completion
//   mem_en/we/addr/wdata        registered memory command
//   mem_rdata                   memory read data, valid in last access cycle
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CPU_ACC = 2'd1;
  localparam logic [1:0] ST_EXT_ACC = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  // A one-cycle access still needs a 1-bit counter.
  localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

  logic [1:0]          state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [STARVE_W-1:0] starve_q,    starve_d;
  logic                owner_q,     owner_d;
  logic                mem_en_q,    mem_en_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ext_rdata_q, ext_rdata_d;
  logic                ext_ack_q,   ext_ack_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    ext_ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ext_req && (!cpu_req || starve_q == STARVE_TOP)) begin
          state_d     = ST_EXT_ACC;
          owner_d     = OWN_EXT;
          starve_d    = '0;
          cnt_d       = '0;
          mem_en_d    = 1'b1;
          mem_we_d    = ext_we;
          mem_addr_d  = ext_addr;
          mem_wdata_d = ext_wdata;
        end else if (cpu_req) begin
          state_d     = ST_CPU_ACC;
          owner_d     = OWN_CPU;
          cnt_d       = '0;
          mem_en_d    = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          // Only a win over a waiting EXT request counts towards starvation.
          if (!ext_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_TOP) begin
            starve_d = starve_q + STARVE_W'(1);
          end
        end else begin
          starve_d = '0;
        end
      end

      ST_CPU_ACC, ST_EXT_ACC: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = ST_RESP;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (!mem_we_q) begin
            if (owner_q == OWN_EXT) ext_rdata_d = mem_rdata;
            else                    cpu_rdata_d = mem_rdata;
          end
          // Registered so the pulse lines up with the response cycle.
          ext_ack_d = (owner_q == OWN_EXT);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state and outputs update with non-blocking assignments so every
  // flop samples the values from before this edge.
  // NOTE: the data registers are reset too, so the memory bus and read-data
  // outputs come out of reset at zero rather than unknown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      owner_q     <= OWN_CPU;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
      ext_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
      ext_ack_q   <= ext_ack_d;
    end
  end

  // The pipeline is released only in the CPU's own response cycle.
  assign cpu_stall = cpu_req && !(state_q == ST_RESP && owner_q == OWN_CPU);

  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign ext_ack   = ext_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port data memory between two requesters: the pipeline MEM stage (CPU) and an external loader/debug port (EXT).
- Drives the memory for a fixed MEM_LAT-cycle access and stalls the pipeline until read data or write completion is available.
- Sits between the MEM stage and data_memory. The CPU has priority; a starvation counter guarantees EXT progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles each memory access occupies (>=1).
- STARVE_MAX, 8, number of consecutive CPU wins over a pending EXT request before EXT is forced a grant (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  MEM stage access request (memread|memwrite); held until the stall drops.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  ALU result address.
- cpu_wdata  in  DATA_W  store data (rdata2out).
- cpu_rdata  out  DATA_W  registered load data; valid while cpu_stall=0 in the response cycle.
- cpu_stall  out  1  pipeline stall request.
- ext_req  in  1  external request; held until ext_ack.
- ext_we  in  1  external write enable.
- ext_addr  in  ADDR_W  external address.
- ext_wdata  in  DATA_W  external write data.
- ext_rdata  out  DATA_W  registered external read data.
- ext_ack  out  1  one-cycle completion pulse.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last access cycle.

Behaviour:
- States: IDLE, CPU_ACC, EXT_ACC, RESP. Counter cnt spans 0..MEM_LAT-1. Flag owner records CPU or EXT.
- Reset (async): state=IDLE, cnt=0, starve=0. All mem_* outputs, cpu_rdata, ext_rdata and ext_ack are 0. cpu_stall follows its combinational equation (cpu_req & state!=RESP-for-CPU).
- IDLE arbitration:
  - If ext_req and (!cpu_req or starve==STARVE_MAX): go to EXT_ACC; starve=0.
  - Else if cpu_req: go to CPU_ACC; starve increments (saturating) if ext_req is also high.
  - If ext_req is low, starve=0.
  - On entry to either ACC state, the winner's we/addr/wdata are latched into the mem_* registers, mem_en=1, cnt=0.
- CPU_ACC / EXT_ACC:
  - mem_* held stable for exactly MEM_LAT cycles; cnt increments each cycle.
  - At cnt==MEM_LAT-1, mem_rdata is captured into cpu_rdata or ext_rdata (reads only; writes leave it unchanged).
  - mem_en, mem_we drop to 0; state goes to RESP.
- RESP, one cycle:
  - Owner CPU: cpu_stall=0 and cpu_rdata is valid.
  - Owner EXT: ext_ack=1.
  - Next state is always IDLE. There is no back-to-back access: one IDLE cycle separates accesses.
- cpu_stall = cpu_req & !(state==RESP & owner==CPU); combinational.
  - Load or store latency seen by the pipeline is MEM_LAT+1 stalled cycles, released in cycle MEM_LAT+2.
- Requester dropping its request mid-access (flush): the access completes and any write is committed. No ack or stall effect beyond the formula.
- Reset mid-access: the access is aborted immediately. A write may be partially applied; this is acceptable.
- Simultaneous requests with starve<STARVE_MAX: CPU wins.

Test Plan:
1. MEM_LAT=2, CPU read of addr 0x10, mem_rdata=0xDEADBEEF -> cpu_stall high for 3 cycles; cpu_rdata=0xDEADBEEF with cpu_stall=0 in the 4th cycle; mem_en high exactly 2 cycles.
2. CPU write addr 0x20 data 0x1234 -> mem_we=1, mem_addr=0x20, mem_wdata=0x1234 for 2 cycles; stall released in cycle 4; cpu_rdata unchanged.
3. EXT read addr 0x40 with cpu_req low -> ext_ack pulses once, 3 cycles after the request; ext_rdata=memory value; cpu_stall stays 0.
4. STARVE_MAX=8, cpu_req and ext_req held continuously -> 8 CPU accesses, then 1 EXT access; starve returns to 0.
5. cpu_req dropped during CPU_ACC of a write -> the write still reaches memory for 2 cycles; the FSM returns to IDLE; no stall afterwards.
6. rst asserted mid EXT_ACC -> mem_en=0 and state=IDLE immediately, with no ext_ack; the next request is served normally.
